// File: rtl/mux_wb_pkg.sv
// Shared constants for the writeback stage: load-size codes and FSM state encoding.
package mux_wb_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mux_writeback_stage_load_align.sv
// Big-endian byte/half/word extraction from a memory read word, with sign or zero extension.
// Purely combinational; sizes other than byte/half pass the whole word through.
module load_align
    import mux_wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[31:24];
            2'd1:    byte_sel = rdata_i[23:16];
            2'd2:    byte_sel = rdata_i[15:8];
            default: byte_sel = rdata_i[7:0];
        endcase
        // Half-word alignment only looks at offset bit 1.
        half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        case (size_i)
            LS_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            LS_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mux_writeback_stage.sv
// MIPS writeback stage: source mux for non-loads (1 cycle), loads wait for mem ack then align (1 + wait).
// out_ready drops while a load waits; optional memory-wait timeout under MUX_WB_TIMEOUT_EN.
module mux_writeback_stage
    import mux_wb_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int SEL_W          = $clog2(NUM_SRC),
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_valid,
    output logic                    out_ready,
    input  logic [NUM_SRC*32-1:0]   in_src_data,
    input  logic [SEL_W-1:0]        in_select,
    input  logic                    in_is_load,
    input  logic [1:0]              in_load_size,
    input  logic                    in_load_signed,
    input  logic [1:0]              in_byte_offset,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic                    in_reg_write,
    input  logic [31:0]             in_mem_rdata,
    input  logic                    in_mem_ack,
    output logic                    out_wb_valid,
    output logic [31:0]             out_wb_data,
    output logic [REG_ADDR_W-1:0]   out_wb_rd,
    output logic                    out_wb_we,
    output logic                    out_wb_err
);

    if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mux_writeback_stage: NUM_SRC must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    wb_state_e             state_q, state_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_we_q, wb_we_d;
    logic                  wb_err_q, wb_err_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic                  ld_we_q, ld_we_d;
    logic                  ld_signed_q, ld_signed_d;
    logic [1:0]            ld_size_q, ld_size_d;
    logic [1:0]            ld_off_q, ld_off_d;
    logic [31:0]           sel_data;
    logic [31:0]           aligned;
    logic                  accept;
    logic                  timeout_hit;

    assign out_ready = (state_q == ST_RUN);
    assign accept    = in_valid && out_ready;

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_data = 32'h0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(in_select) == i) sel_data = in_src_data[32*i +: 32];
        end
    end

    load_align u_load_align (
        .rdata_i  (in_mem_rdata),
        .size_i   (ld_size_q),
        .signed_i (ld_signed_q),
        .offset_i (ld_off_q),
        .data_o   (aligned)
    );

`ifdef MUX_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires on the last allowed wait cycle; a concurrent ack still wins in the FSM.
    assign timeout_hit = (state_q == ST_WAIT_MEM) && !in_mem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept && in_is_load)                          cnt_d = '0;
        else if (state_q == ST_WAIT_MEM && !in_mem_ack)    cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_err_d    = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        ld_rd_d     = ld_rd_q;
        ld_we_d     = ld_we_q;
        ld_signed_d = ld_signed_q;
        ld_size_d   = ld_size_q;
        ld_off_d    = ld_off_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (in_is_load) begin
                        ld_rd_d     = in_rd;
                        ld_we_d     = in_reg_write;
                        ld_signed_d = in_load_signed;
                        ld_size_d   = in_load_size;
                        ld_off_d    = in_byte_offset;
                        state_d     = ST_WAIT_MEM;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = sel_data;
                        wb_rd_d    = in_rd;
                        wb_we_d    = in_reg_write;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (in_mem_ack) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = aligned;
                    wb_rd_d    = ld_rd_q;
                    wb_we_d    = ld_we_q;
                    state_d    = ST_RUN;
                end else if (timeout_hit) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = 32'h0;
                    wb_err_d   = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= ST_RUN;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_err_q    <= 1'b0;
            wb_data_q   <= 32'h0;
            wb_rd_q     <= '0;
            ld_rd_q     <= '0;
            ld_we_q     <= 1'b0;
            ld_signed_q <= 1'b0;
            ld_size_q   <= LS_WORD;
            ld_off_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_err_q    <= wb_err_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            ld_rd_q     <= ld_rd_d;
            ld_we_q     <= ld_we_d;
            ld_signed_q <= ld_signed_d;
            ld_size_q   <= ld_size_d;
            ld_off_q    <= ld_off_d;
        end
    end

    assign out_wb_valid = wb_valid_q;
    assign out_wb_data  = wb_data_q;
    assign out_wb_rd    = wb_rd_q;
    assign out_wb_we    = wb_we_q;
    assign out_wb_err   = wb_err_q;

endmodule

// File: tb/tb_mux_writeback_stage.sv
// Directed bench for mux_writeback_stage with a transaction-level reference model checked every cycle.
module tb_mux_writeback_stage;

    localparam int NS = 4;
    localparam int TO = 16;

    logic          in_clk = 1'b0;
    logic          in_rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready;
    logic [127:0]  in_src_data = '0;
    logic [2:0]    in_select = '0;
    logic          in_is_load = 1'b0;
    logic [1:0]    in_load_size = 2'b00;
    logic          in_load_signed = 1'b0;
    logic [1:0]    in_byte_offset = 2'b00;
    logic [4:0]    in_rd = '0;
    logic          in_reg_write = 1'b0;
    logic [31:0]   in_mem_rdata = '0;
    logic          in_mem_ack = 1'b0;
    logic          out_wb_valid;
    logic [31:0]   out_wb_data;
    logic [4:0]    out_wb_rd;
    logic          out_wb_we;
    logic          out_wb_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] src_tab [4] = '{32'h1111_0001, 32'h2222_0002, 32'hDEAD_BEEF, 32'h4444_0004};

    mux_writeback_stage #(
        .NUM_SRC(NS), .SEL_W(3), .REG_ADDR_W(5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready(out_ready),
        .in_src_data(in_src_data), .in_select(in_select), .in_is_load(in_is_load),
        .in_load_size(in_load_size), .in_load_signed(in_load_signed),
        .in_byte_offset(in_byte_offset), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_mem_rdata(in_mem_rdata), .in_mem_ack(in_mem_ack),
        .out_wb_valid(out_wb_valid), .out_wb_data(out_wb_data), .out_wb_rd(out_wb_rd),
        .out_wb_we(out_wb_we), .out_wb_err(out_wb_err)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: what the register file must see, derived from instruction semantics.
    function automatic logic [31:0] pick(input logic [127:0] all, input logic [2:0] sel);
        logic [127:0] sh;
        if (int'(sel) >= NS) return 32'h0;
        sh = all >> (32 * int'(sel));
        return sh[31:0];
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sg, input logic [1:0] off);
        int unsigned v;
        int          bits;
        if (sz == 2'd0) begin
            bits = 8;
            v = (w >> (8 * (3 - int'(off)))) & 32'hFF;
        end else if (sz == 2'd1) begin
            bits = 16;
            v = (w >> (off[1] ? 0 : 16)) & 32'hFFFF;
        end else begin
            return w;
        end
        if (sg && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    bit          m_busy = 0;
    int          m_waited = 0;
    logic [4:0]  m_rd = '0;
    logic        m_we = 0, m_sg = 0;
    logic [1:0]  m_sz = '0, m_off = '0;
    logic        e_valid = 0, e_we = 0, e_err = 0;
    logic [31:0] e_data = '0;
    logic [4:0]  e_rd = '0;

    always @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            m_busy = 0; e_valid = 0; e_we = 0; e_err = 0; e_data = '0; e_rd = '0;
        end else begin
            e_valid = 0;
            e_err   = 0;
            if (!m_busy) begin
                if (in_valid && in_is_load) begin
                    m_busy = 1; m_waited = 0; m_rd = in_rd; m_we = in_reg_write;
                    m_sz = in_load_size; m_sg = in_load_signed; m_off = in_byte_offset;
                end else if (in_valid) begin
                    e_valid = 1; e_data = pick(in_src_data, in_select);
                    e_rd = in_rd; e_we = in_reg_write;
                end
            end else if (in_mem_ack) begin
                e_valid = 1; e_data = extract(in_mem_rdata, m_sz, m_sg, m_off);
                e_rd = m_rd; e_we = m_we; m_busy = 0;
            end else begin
                m_waited++;
`ifdef MUX_WB_TIMEOUT_EN
                if (m_waited == TO) begin
                    e_valid = 1; e_data = 0; e_we = 0; e_err = 1; m_busy = 0;
                end
`endif
            end
        end
    end

    always @(negedge in_clk) begin
        if (!in_rst) begin
            check("m_ready", out_ready, !m_busy);
            check("m_valid", out_wb_valid, e_valid);
            check("m_err", out_wb_err, e_err);
            if (e_valid) begin
                check("m_data", out_wb_data, e_data);
                check("m_rd", out_wb_rd, e_rd);
                check("m_we", out_wb_we, e_we);
            end
        end
    end

    task automatic drive_nl(input logic [2:0] sel, input logic [4:0] rd, input logic we);
        in_valid = 1; in_is_load = 0; in_select = sel; in_rd = rd; in_reg_write = we;
    endtask

    // Load that is acked in wait cycle waits+1; checks the pulse against a hand value.
    task automatic do_load(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                           input logic [31:0] rdata, input logic [4:0] rd, input int waits,
                           input logic [31:0] exp);
        in_valid = 1; in_is_load = 1; in_load_size = sz; in_load_signed = sg;
        in_byte_offset = off; in_rd = rd; in_reg_write = 1; in_mem_rdata = ~rdata; in_mem_ack = 0;
        @(negedge in_clk);
        in_valid = 0; in_is_load = 0;
        for (int i = 0; i < waits; i++) begin
            check("ld_wait_ready", out_ready, 0);
            @(negedge in_clk);
        end
        check("ld_ack_ready", out_ready, 0);
        in_mem_rdata = rdata; in_mem_ack = 1;
        @(negedge in_clk);
        in_mem_ack = 0;
        check("ld_valid", out_wb_valid, 1);
        check("ld_data", out_wb_data, exp);
        check("ld_rd", out_wb_rd, rd);
        check("ld_we", out_wb_we, 1);
        check("ld_err", out_wb_err, 0);
        check("ld_pulse_ready", out_ready, 1);
        @(negedge in_clk);
        check("ld_after_valid", out_wb_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        in_src_data = {src_tab[3], src_tab[2], src_tab[1], src_tab[0]};
        repeat (2) @(negedge in_clk);
        check("rst_valid", out_wb_valid, 0);
        check("rst_data", out_wb_data, 0);
        check("rst_rd", out_wb_rd, 0);
        check("rst_we", out_wb_we, 0);
        check("rst_err", out_wb_err, 0);
        check("rst_ready", out_ready, 1);
        in_rst = 0;
        @(negedge in_clk);

        drive_nl(3'd2, 5'd7, 1'b1);
        @(negedge in_clk);
        in_valid = 0;
        check("nl_valid", out_wb_valid, 1);
        check("nl_data", out_wb_data, 32'hDEADBEEF);
        check("nl_rd", out_wb_rd, 7);
        check("nl_we", out_wb_we, 1);
        @(negedge in_clk);
        check("nl_after_valid", out_wb_valid, 0);

        do_load(2'b00, 1'b1, 2'd1, 32'h12F45678, 5'd3, 3, 32'hFFFFFFF4);
        do_load(2'b01, 1'b0, 2'd2, 32'h1234ABCD, 5'd5, 0, 32'h0000ABCD);
        do_load(2'b10, 1'b0, 2'd3, 32'h1234ABCD, 5'd6, 1, 32'h1234ABCD);
        do_load(2'b11, 1'b1, 2'd1, 32'h1234ABCD, 5'd8, 0, 32'h1234ABCD);
        do_load(2'b01, 1'b1, 2'd1, 32'h8001FFFF, 5'd10, 2, 32'hFFFF8001);
        do_load(2'b00, 1'b0, 2'd3, 32'hFFFFFF80, 5'd11, 0, 32'h00000080);

        drive_nl(3'd5, 5'd1, 1'b1);
        @(negedge in_clk);
        in_valid = 0;
        check("sel_oor_data", out_wb_data, 32'h0);

        for (int i = 0; i < 4; i++) begin
            drive_nl(3'(i), 5'(i + 16), i[0]);
            @(negedge in_clk);
            check("b2b_valid", out_wb_valid, 1);
            check("b2b_data", out_wb_data, src_tab[i]);
            check("b2b_we", out_wb_we, i[0]);
            check("b2b_ready", out_ready, 1);
        end
        in_valid = 0;
        @(negedge in_clk);
        check("b2b_end_valid", out_wb_valid, 0);

        // New instruction presented alongside the ack must wait for the next cycle.
        in_valid = 1; in_is_load = 1; in_load_size = 2'b10; in_rd = 5'd4; in_reg_write = 1;
        @(negedge in_clk);
        drive_nl(3'd1, 5'd9, 1'b1);
        in_mem_rdata = 32'hCAFEF00D; in_mem_ack = 1;
        @(negedge in_clk);
        check("coll_ld_data", out_wb_data, 32'hCAFEF00D);
        check("coll_ld_rd", out_wb_rd, 4);
        @(negedge in_clk);
        in_valid = 0; in_mem_ack = 0;
        check("coll_nl_valid", out_wb_valid, 1);
        check("coll_nl_data", out_wb_data, 32'h2222_0002);
        check("coll_nl_rd", out_wb_rd, 9);
        @(negedge in_clk);

        in_valid = 1; in_is_load = 1; in_load_size = 2'b10; in_rd = 5'd12; in_reg_write = 1;
        @(negedge in_clk);
        in_valid = 0; in_is_load = 0;
        @(negedge in_clk);
        in_rst = 1;
        #1;
        check("mrst_ready", out_ready, 1);
        check("mrst_data", out_wb_data, 0);
        check("mrst_rd", out_wb_rd, 0);
        @(negedge in_clk);
        in_rst = 0; in_mem_rdata = 32'h5555AAAA; in_mem_ack = 1;
        @(negedge in_clk);
        in_mem_ack = 0;
        check("mrst_ack_valid", out_wb_valid, 0);
        check("mrst_ack_data", out_wb_data, 0);
        check("mrst_ack_we", out_wb_we, 0);
        check("mrst_ack_ready", out_ready, 1);
        @(negedge in_clk);
        check("mrst_late_valid", out_wb_valid, 0);

`ifdef MUX_WB_TIMEOUT_EN
        in_valid = 1; in_is_load = 1; in_load_size = 2'b10; in_rd = 5'd13; in_reg_write = 1;
        in_mem_rdata = 32'h0BAD0BAD;
        @(negedge in_clk);
        in_valid = 0; in_is_load = 0;
        for (int i = 0; i < TO; i++) begin
            check("to_wait_valid", out_wb_valid, 0);
            @(negedge in_clk);
        end
        check("to_valid", out_wb_valid, 1);
        check("to_err", out_wb_err, 1);
        check("to_we", out_wb_we, 0);
        check("to_data", out_wb_data, 0);
        check("to_ready", out_ready, 1);
        @(negedge in_clk);
        check("to_err_pulse", out_wb_err, 0);
        do_load(2'b10, 1'b0, 2'd0, 32'h600DF00D, 5'd14, TO - 1, 32'h600DF00D);
`endif

        repeat (2) @(negedge in_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
